nib_track_writer: RTL and testbench
===================================

# nib_track_writer

Writes the modified NIB track buffer back to the SD image through hps_io's sector-write channel. It is the write-side counterpart of the top-level track loader. It marks the 6656-byte track buffer dirty whenever the disk controller writes it, then flushes the 13 sectors (512 bytes each) to LBA 13*track. A flush happens before the loader replaces the buffer on a head-track change, or on an explicit flush request. It sits in the emu top between apple2_top's track RAM port and hps_io.

## Interface
Parameters:
- SECTORS, 13, sectors per NIB track
- none other

Ports:
- clk_sys  in  1  system clock (14 MHz domain)
- reset  in  1  asynchronous, active-high
- track  in  6  current head track from apple2_top
- img_mounted  in  1  hps_io mount pulse
- img_present  in  1  |img_size
- track_we  in  1  controller wrote the track buffer this cycle
- flush  in  1  single-cycle request to write back now
- hold  out  1  combinational; loader must not start a read while high
- busy  out  1  writeback in progress; OR into cpu_wait
- done  out  1  one-cycle pulse after the last sector completes
- sd_lba  out  32  sector address
- sd_wr  out  1  write request to hps_io
- sd_ack  in  1  hps_io transfer acknowledge
- sd_buff_addr  in  9  byte index requested by hps_io
- sd_buff_din  out  8  byte to hps_io; equals tram_dout
- tram_addr  out  13  track RAM read address; combinational {sec[3:0], sd_buff_addr}
- tram_dout  in  8  track RAM read data, registered, 1-cycle latency

## Operation
- Registers: dirty, redirty, dirty_track[5:0], wtrack[5:0], sec[3:0], state, old_ack.
- Dirty marking:
  - track_we with dirty=0 sets dirty and sets dirty_track to track.
  - track_we with busy=1 sets redirty.
- hold = busy | (dirty & img_present & (track != dirty_track)).
- States:
  - IDLE
    - Trigger = dirty & img_present & ((track != dirty_track) | flush).
    - On trigger: set wtrack to dirty_track, sec to 0, sd_lba to 13*dirty_track, sd_wr to 1, busy to 1, redirty to 0. Go to REQ.
  - REQ
    - Rising sd_ack: if sec == SECTORS-1, drop sd_wr. Go to XFER.
  - XFER
    - hps_io sweeps sd_buff_addr 0..511. sd_buff_din follows one cycle behind the address; hps_io's read side tolerates this latency.
    - Falling sd_ack, sector not last: increment sec and sd_lba, return to REQ with sd_wr still 1.
    - Falling sd_ack, last sector: go to IDLE, clear busy, pulse done, set dirty to redirty.
- img_mounted pulse in any state:
  - Discard the old image's data: clear dirty and redirty.
  - In IDLE it overrides a same-cycle trigger, so no writeback starts.
  - In REQ or XFER the current pass is completed unchanged; hps_io guards the image swap.
- LBA arithmetic:
  - 13*track is at most 819; plus 12 gives 831, which fits 10 bits.
  - sd_lba is zero-extended to 32 bits.
- flush while busy: ignored.
- track_we while clean and busy: sets redirty only. dirty_track keeps the old value.

## Timing
- Reset values: sd_wr=0, sd_lba=0, busy=0, done=0, dirty=0, redirty=0, state=IDLE, sec=0.
- Reset mid-transfer: sd_wr and busy drop asynchronously and dirty data is lost. hps_io aborts on the sd_wr drop.
- Trigger to sd_wr=1: 1 clock. hold is high in the trigger cycle itself.
- Sector edges are detected on sd_ack with old_ack, so each edge costs 1 clock.
- done is high for exactly 1 clock, in the cycle busy falls.
- Total writeback duration is set by hps_io, roughly 13 sector handshakes.

## Configuration
- NIB_WRITE_PROTECT_EN
  - Defined: adds input wp (1 bit). While wp=1, track_we is ignored and no trigger fires. A writeback already in progress completes.
  - Undefined: no wp port; all writes are honoured.

## Structure
- Shared package apple2_disk_pkg:
  - NIB_SECTORS=13, SECTOR_BYTES=512, TRACK_BITS=6.
  - State enum nib_wr_state_t {IDLE, REQ, XFER}.
  - lba_of_track() helper.
- The loader uses the same package.
- No sub-module; a single FSM file.

## Test plan
- Dirty track 3 (track_we), then track changes to 4:
  - hold=1 in the same cycle.
  - sd_wr rises next clock.
  - LBAs 39..51 are issued across 13 ack pulses.
  - sd_wr drops on the 13th ack rise.
  - done pulses once, then busy=0, hold=0, dirty=0.
- Track RAM preloaded with byte = addr[7:0]^sec; the bench's hps_io model samples sd_buff_din one cycle after sd_buff_addr. All 6656 bytes must match.
- Clean buffer, track 5 to 6: sd_wr stays 0, hold stays 0, busy stays 0.
- Dirty track 7, img_mounted and a track change in the same cycle: no sd_wr, dirty=0.
- Dirty track 0 with flush pulse and no track change: LBAs 0..12 written, then dirty=0.
- Reset asserted during XFER of sector 5: sd_wr=0 and busy=0 without waiting for a clock edge; a later track change starts no writeback.

Source files
------------

// File: rtl/apple2_disk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apple2_disk_pkg
// Description : Shared NIB track geometry, writeback state encoding and the
//               track-to-LBA helper used by the track loader and writer.
// Revision    : 1.0
// ============================================================================
package apple2_disk_pkg;

    localparam int NIB_SECTORS  = 13;
    localparam int SECTOR_BYTES = 512;
    localparam int TRACK_BITS   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } nib_wr_state_t;

    // First sector of a track; 13*63+12 = 831 fits in 10 bits.
    function automatic logic [31:0] lba_of_track(input logic [TRACK_BITS-1:0] t);
        logic [9:0] l;
        l = {4'd0, t} * 10'd13;
        return {22'd0, l};
    endfunction

endpackage
`default_nettype wire

// File: rtl/nib_track_writer.sv
`default_nettype none
// ============================================================================
// Module      : nib_track_writer
// Description : Flushes the dirty 6656-byte NIB track buffer back to the SD
//               image as 13 sector writes through the hps_io write channel.
//               Optional NIB_WRITE_PROTECT_EN adds a wp input.
// Revision    : 1.0
// ============================================================================
module nib_track_writer
    import apple2_disk_pkg::*;
#(
    parameter int SECTORS = NIB_SECTORS
) (
    input  logic                  clk_sys,
    input  logic                  reset,
`ifdef NIB_WRITE_PROTECT_EN
    input  logic                  wp,
`endif
    input  logic [TRACK_BITS-1:0] track,
    input  logic                  img_mounted,
    input  logic                  img_present,
    input  logic                  track_we,
    input  logic                  flush,
    output logic                  hold,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           sd_lba,
    output logic                  sd_wr,
    input  logic                  sd_ack,
    input  logic [8:0]            sd_buff_addr,
    output logic [7:0]            sd_buff_din,
    output logic [12:0]           tram_addr,
    input  logic [7:0]            tram_dout
);

    logic                  r_dirty;
    logic                  r_redirty;
    logic [TRACK_BITS-1:0] r_dirty_track;
    logic [TRACK_BITS-1:0] r_wtrack;
    logic [3:0]            r_sec;
    nib_wr_state_t         r_state;
    logic                  r_old_ack;

    logic w_wr_ok;
    logic w_we;
    logic w_trigger;
    logic w_ack_rise;
    logic w_ack_fall;
    logic w_last;

`ifdef NIB_WRITE_PROTECT_EN
    assign w_wr_ok = ~wp;
`else
    assign w_wr_ok = 1'b1;
`endif

    assign w_we       = track_we & w_wr_ok;
    assign w_trigger  = r_dirty & img_present & w_wr_ok & ~img_mounted
                      & ((track != r_dirty_track) | flush);
    assign w_ack_rise = sd_ack & ~r_old_ack;
    assign w_ack_fall = ~sd_ack & r_old_ack;
    assign w_last     = (r_sec == 4'(SECTORS - 1));

    assign hold        = busy | (r_dirty & img_present & (track != r_dirty_track));
    assign tram_addr   = {r_sec, sd_buff_addr};
    assign sd_buff_din = tram_dout;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_dirty       <= 1'b0;
            r_redirty     <= 1'b0;
            r_dirty_track <= '0;
            r_wtrack      <= '0;
            r_sec         <= 4'd0;
            r_state       <= IDLE;
            r_old_ack     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            sd_lba        <= 32'd0;
            sd_wr         <= 1'b0;
        end else begin
            done      <= 1'b0;
            r_old_ack <= sd_ack;

            // A write during a pass is remembered so the buffer stays dirty afterwards.
            if (w_we) begin
                if (busy) begin
                    r_redirty <= 1'b1;
                end else if (!r_dirty) begin
                    r_dirty       <= 1'b1;
                    r_dirty_track <= track;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_wtrack  <= r_dirty_track;
                        r_sec     <= 4'd0;
                        sd_lba    <= lba_of_track(r_dirty_track);
                        sd_wr     <= 1'b1;
                        busy      <= 1'b1;
                        r_redirty <= 1'b0;
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    if (w_ack_rise) begin
                        if (w_last) begin
                            sd_wr <= 1'b0;
                        end
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_ack_fall) begin
                        if (!w_last) begin
                            r_sec   <= r_sec + 4'd1;
                            sd_lba  <= lba_of_track(r_wtrack) + {28'd0, r_sec} + 32'd1;
                            r_state <= REQ;
                        end else begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_dirty <= r_redirty | w_we;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A newly mounted image invalidates whatever the buffer held.
            if (img_mounted) begin
                r_dirty   <= 1'b0;
                r_redirty <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nib_track_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nib_track_writer
// Description : Directed bench for nib_track_writer with an hps_io write-side
//               model and a registered track RAM model.
// Revision    : 1.0
// ============================================================================
module tb_nib_track_writer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [5:0]  track;
    logic        img_mounted;
    logic        img_present;
    logic        track_we;
    logic        flush;
    logic        hold;
    logic        busy;
    logic        done;
    logic [31:0] sd_lba;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_din;
    logic [12:0] tram_addr;
    logic [7:0]  tram_dout;

    logic [7:0]  tram [0:8191];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_sys = ~clk_sys;

    nib_track_writer dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .track        (track),
        .img_mounted  (img_mounted),
        .img_present  (img_present),
        .track_we     (track_we),
        .flush        (flush),
        .hold         (hold),
        .busy         (busy),
        .done         (done),
        .sd_lba       (sd_lba),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_din  (sd_buff_din),
        .tram_addr    (tram_addr),
        .tram_dout    (tram_dout)
    );

    always @(posedge clk_sys) tram_dout <= tram[tram_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic mark_dirty(input logic [5:0] t);
        track    = t;
        track_we = 1'b1;
        cycles(1);
        track_we = 1'b0;
    endtask

    // Confirm the buffer is clean: a flush must start nothing.
    task automatic check_clean(input string tag);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        cycles(2);
        check_eq({tag, "_sd_wr"}, {31'd0, sd_wr}, 32'd0);
        check_eq({tag, "_busy"},  {31'd0, busy},  32'd0);
    endtask

    // hps_io model: full 13-sector pass, or reset mid-sweep at abort_sec.
    task automatic writeback(input int start_lba, input int abort_sec);
        int bad;
        logic [8:0] prev;
        bad = 0;
        prev = 9'd0;
        for (int s = 0; s < 13; s++) begin
            check_eq($sformatf("lba_s%0d", s), sd_lba, 32'(start_lba + s));
            check_eq($sformatf("wr_req_s%0d", s), {31'd0, sd_wr}, 32'd1);
            sd_ack = 1'b1;
            for (int i = 0; i <= 512; i++) begin
                cycles(1);
                if (i == 0)
                    check_eq($sformatf("wr_after_rise_s%0d", s), {31'd0, sd_wr}, (s == 12) ? 32'd0 : 32'd1);
                if (i > 0 && sd_buff_din !== (prev[7:0] ^ 8'(s)))
                    bad++;
                if (s == abort_sec && i == 100) begin
                    #2 reset = 1'b1;
                    #1;
                    check_eq("async_rst_sd_wr", {31'd0, sd_wr}, 32'd0);
                    check_eq("async_rst_busy",  {31'd0, busy},  32'd0);
                    sd_ack = 1'b0;
                    cycles(2);
                    reset = 1'b0;
                    return;
                end
                if (i < 512) begin
                    sd_buff_addr = 9'(i);
                    prev = 9'(i);
                end
            end
            sd_ack = 1'b0;
            cycles(1);
            if (s < 12) begin
                check_eq($sformatf("busy_mid_s%0d", s), {31'd0, busy}, 32'd1);
            end else begin
                check_eq("done_pulse", {31'd0, done}, 32'd1);
                check_eq("busy_end",   {31'd0, busy}, 32'd0);
            end
            cycles(1);
        end
        check_eq("done_single", {31'd0, done}, 32'd0);
        check_eq("bytes_bad", 32'(bad), 32'd0);
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) tram[a] = 8'(a) ^ {4'd0, 4'(a >> 9)};
        reset        = 1'b1;
        track        = 6'd3;
        img_mounted  = 1'b0;
        img_present  = 1'b1;
        track_we     = 1'b0;
        flush        = 1'b0;
        sd_ack       = 1'b0;
        sd_buff_addr = 9'd0;
        cycles(3);
        check_eq("rst_sd_wr", {31'd0, sd_wr}, 32'd0);
        check_eq("rst_busy",  {31'd0, busy},  32'd0);
        check_eq("rst_done",  {31'd0, done},  32'd0);
        check_eq("rst_lba",   sd_lba,         32'd0);
        check_eq("rst_hold",  {31'd0, hold},  32'd0);
        reset = 1'b0;
        cycles(1);

        // Dirty track 3, head moves to 4.
        mark_dirty(6'd3);
        track = 6'd4;
        #1;
        check_eq("t3_hold_same_cycle", {31'd0, hold}, 32'd1);
        check_eq("t3_sd_wr_not_yet",   {31'd0, sd_wr}, 32'd0);
        cycles(1);
        check_eq("t3_sd_wr_next", {31'd0, sd_wr}, 32'd1);
        check_eq("t3_busy",       {31'd0, busy},  32'd1);
        writeback(39, -1);
        check_eq("t3_hold_after", {31'd0, hold}, 32'd0);
        check_clean("t3_clean");

        // Clean buffer, track 5 -> 6.
        track = 6'd5;
        cycles(2);
        track = 6'd6;
        #1;
        check_eq("clean_hold", {31'd0, hold}, 32'd0);
        cycles(3);
        check_eq("clean_sd_wr", {31'd0, sd_wr}, 32'd0);
        check_eq("clean_busy",  {31'd0, busy},  32'd0);

        // Dirty track 7, mount and track change together.
        mark_dirty(6'd7);
        track       = 6'd8;
        img_mounted = 1'b1;
        cycles(1);
        img_mounted = 1'b0;
        cycles(2);
        check_eq("mnt_sd_wr", {31'd0, sd_wr}, 32'd0);
        check_eq("mnt_hold",  {31'd0, hold},  32'd0);
        check_clean("mnt_clean");

        // Dirty track 0, explicit flush.
        mark_dirty(6'd0);
        cycles(1);
        check_eq("fl_no_auto", {31'd0, sd_wr}, 32'd0);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        check_eq("fl_sd_wr", {31'd0, sd_wr}, 32'd1);
        writeback(0, -1);
        check_clean("fl_clean");

        // Reset during sector 5 of a track 10 writeback.
        mark_dirty(6'd10);
        track = 6'd11;
        cycles(1);
        writeback(130, 5);
        track = 6'd12;
        cycles(4);
        check_eq("post_rst_sd_wr", {31'd0, sd_wr}, 32'd0);
        check_eq("post_rst_busy",  {31'd0, busy},  32'd0);
        check_eq("post_rst_hold",  {31'd0, hold},  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
